// File: rtl/mlp_bus_pkg.sv
// Shared address map, register bit positions and region encoding for the
// Multilayer_Perceptron host bus responder.
package mlp_bus_pkg;

    localparam logic [31:0] A_ID     = 32'h0000_0000;
    localparam logic [31:0] A_CTRL   = 32'h0000_0004;
    localparam logic [31:0] A_STATUS = 32'h0000_0008;
    localparam logic [31:0] A_N      = 32'h0000_0010;
    localparam logic [31:0] A_M      = 32'h0000_0014;
    localparam logic [31:0] A_H      = 32'h0000_0018;

    localparam logic [31:0] INPUT_BASE  = 32'h0000_1000;
    localparam logic [31:0] INPUT_LIMIT = 32'h0000_17FF;
    localparam logic [31:0] RES_BASE    = 32'h0000_1800;
    localparam logic [31:0] RES_LIMIT   = 32'h0000_18FF;
    localparam logic [31:0] HID_BASE    = 32'h0000_8000;
    localparam logic [31:0] HID_LIMIT   = 32'h0000_9FFF;
    localparam logic [31:0] OUTW_BASE   = 32'h0000_A000;
    localparam logic [31:0] OUTW_LIMIT  = 32'h0000_BFFF;

    localparam int CTRL_HOST = 0;
    localparam int CTRL_RUN  = 1;
    localparam int ST_DONE   = 0;
    localparam int ST_BUSY   = 1;
    localparam int ST_ERR    = 2;

    localparam logic [31:0] ID_DEFAULT = 32'h4D4C_5001;
    localparam logic [31:0] RD_DEFAULT = 32'hFFFF_FFFF;

    // Encoding doubles as the mem_sel value driven to the memories.
    typedef enum logic [1:0] {
        RGN_INPUT  = 2'd0,
        RGN_HIDDEN = 2'd1,
        RGN_OUTW   = 2'd2,
        RGN_RESULT = 2'd3
    } region_e;

    function automatic logic in_rgn(input logic [31:0] a, input logic [31:0] lo,
                                    input logic [31:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/mlp_addr_decode.sv
// Combinational host address decode into memory region, region-relative
// word address and write permission.
module mlp_addr_decode
    import mlp_bus_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int MEM_AW = 13
) (
    input  logic [ADDR_W-1:0] address,
    output logic [1:0]        region,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              writable,
    output logic              valid
);

    logic [31:0] a32;
    region_e     rgn;

    assign a32    = 32'(address);
    assign region = rgn;

    always_comb begin
        rgn      = RGN_INPUT;
        mem_addr = '0;
        writable = 1'b0;
        valid    = 1'b0;
        if (in_rgn(a32, INPUT_BASE, INPUT_LIMIT)) begin
            rgn      = RGN_INPUT;
            mem_addr = MEM_AW'(a32 - INPUT_BASE);
            writable = 1'b1;
            valid    = 1'b1;
        end else if (in_rgn(a32, RES_BASE, RES_LIMIT)) begin
            rgn      = RGN_RESULT;
            mem_addr = MEM_AW'(a32 - RES_BASE);
            valid    = 1'b1;
        end else if (in_rgn(a32, HID_BASE, HID_LIMIT)) begin
            rgn      = RGN_HIDDEN;
            mem_addr = MEM_AW'(a32 - HID_BASE);
            writable = 1'b1;
            valid    = 1'b1;
        end else if (in_rgn(a32, OUTW_BASE, OUTW_LIMIT)) begin
            rgn      = RGN_OUTW;
            mem_addr = MEM_AW'(a32 - OUTW_BASE);
            writable = 1'b1;
            valid    = 1'b1;
        end
    end

endmodule

// File: rtl/mlp_bus_responder.sv
// Host bus responder for the MLP core: config/status registers, memory write
// strobes with run-time lockout, 1-cycle registered reads, start/done handshake.
module mlp_bus_responder
    import mlp_bus_pkg::*;
#(
    parameter int          ADDR_W   = 16,
    parameter int          DATA_W   = 32,
    parameter int          MEM_AW   = 13,
    parameter logic [31:0] ID_VALUE = ID_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] din,
    input  logic              write,
    input  logic              read,
    output logic [DATA_W-1:0] dout,
    output logic              core_start,
    input  logic              core_done,
    output logic [15:0]       n_reg,
    output logic [15:0]       m_reg,
    output logic [15:0]       h_reg,
    output logic              mem_we,
    output logic [1:0]        mem_sel,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W-1:0] AD_ID     = ADDR_W'(A_ID);
    localparam logic [ADDR_W-1:0] AD_CTRL   = ADDR_W'(A_CTRL);
    localparam logic [ADDR_W-1:0] AD_STATUS = ADDR_W'(A_STATUS);
    localparam logic [ADDR_W-1:0] AD_N      = ADDR_W'(A_N);
    localparam logic [ADDR_W-1:0] AD_M      = ADDR_W'(A_M);
    localparam logic [ADDR_W-1:0] AD_H      = ADDR_W'(A_H);

    // Reads happen on every non-write cycle; the qualifier carries no meaning.
    logic unused_read;
    assign unused_read = read;

    logic              mem_hit, mem_wr_ok;
    logic [1:0]        ctrl;
    logic              st_done, st_busy, st_err;
    logic [2:0]        status;
    logic              locked, wr_ctrl, ctrl_bad, start_req, err_wr;
    logic              rd_vld_q, rd_mem_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] reg_rd;

    mlp_addr_decode #(.ADDR_W(ADDR_W), .MEM_AW(MEM_AW)) u_dec (
        .address  (address),
        .region   (mem_sel),
        .mem_addr (mem_addr),
        .writable (mem_wr_ok),
        .valid    (mem_hit)
    );

    assign locked    = st_busy | ctrl[CTRL_RUN];
    assign mem_we    = write & mem_hit & mem_wr_ok & ~locked;
    assign mem_wdata = din;

    assign wr_ctrl   = write && (address == AD_CTRL);
    assign ctrl_bad  = (din[1:0] == 2'b11);
    assign start_req = wr_ctrl && !ctrl_bad && din[CTRL_RUN] && !ctrl[CTRL_RUN] && !st_busy;

    assign status[ST_DONE] = st_done;
    assign status[ST_BUSY] = st_busy;
    assign status[ST_ERR]  = st_err;

    // Any write that cannot take effect flags ERR.
    always_comb begin
        err_wr = 1'b0;
        if (write) begin
            if (mem_hit) begin
                err_wr = !mem_wr_ok || locked;
            end else begin
                case (address)
                    AD_CTRL:            err_wr = ctrl_bad;
                    AD_N, AD_M, AD_H:   err_wr = st_busy;
                    default:            err_wr = 1'b1;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl       <= '0;
            st_done    <= 1'b0;
            st_busy    <= 1'b0;
            st_err     <= 1'b0;
            core_start <= 1'b0;
            n_reg      <= '0;
            m_reg      <= '0;
            h_reg      <= '0;
        end else begin
            core_start <= start_req;
            if (wr_ctrl) begin
                if (!ctrl_bad) ctrl <= din[1:0];
                st_done <= 1'b0;
                st_err  <= 1'b0;
            end
            if (err_wr) st_err <= 1'b1;
            if (write && !st_busy) begin
                if (address == AD_N) n_reg <= din[15:0];
                if (address == AD_M) m_reg <= din[15:0];
                if (address == AD_H) h_reg <= din[15:0];
            end
            if (core_done) begin
                st_done        <= 1'b1;
                st_busy        <= 1'b0;
                ctrl[CTRL_RUN] <= 1'b0;
            end
            // A fresh start overrides a stray done from an idle core.
            if (start_req) begin
                st_busy        <= 1'b1;
                ctrl[CTRL_RUN] <= 1'b1;
            end
        end
    end

    // Register mux evaluates one edge after the address was sampled, so it
    // sees state updated at the sampling edge and lines up with memory data.
    always_comb begin
        reg_rd = DATA_W'(RD_DEFAULT);
        case (rd_addr_q)
            AD_ID:     reg_rd = DATA_W'(ID_VALUE);
            AD_CTRL:   reg_rd = DATA_W'(ctrl);
            AD_STATUS: reg_rd = DATA_W'(status);
            AD_N:      reg_rd = DATA_W'(n_reg);
            AD_M:      reg_rd = DATA_W'(m_reg);
            AD_H:      reg_rd = DATA_W'(h_reg);
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_vld_q  <= 1'b0;
            rd_mem_q  <= 1'b0;
            rd_addr_q <= '0;
            dout      <= '0;
        end else begin
            rd_vld_q  <= !write;
            rd_mem_q  <= mem_hit;
            rd_addr_q <= address;
            if (rd_vld_q) dout <= rd_mem_q ? mem_rdata : reg_rd;
        end
    end

endmodule

// File: tb/tb_mlp_bus_responder.sv
// Randomized self-checking bench for mlp_bus_responder against a map-level
// reference model of the register/memory behaviour.
module tb_mlp_bus_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] address;
    logic [31:0] din;
    logic        write;
    logic        rd_en;
    logic [31:0] dout;
    logic        core_start;
    logic        core_done;
    logic [15:0] n_reg, m_reg, h_reg;
    logic        mem_we;
    logic [1:0]  mem_sel;
    logic [12:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_err = 0;

    mlp_bus_responder dut (
        .clk(clk), .reset(reset), .address(address), .din(din), .write(write),
        .read(rd_en), .dout(dout), .core_start(core_start), .core_done(core_done),
        .n_reg(n_reg), .m_reg(m_reg), .h_reg(h_reg), .mem_we(mem_we),
        .mem_sel(mem_sel), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [31:0] memval(input logic [1:0] s, input logic [12:0] a);
        return {s, 17'h0, a} ^ 32'h5A5A_0000;
    endfunction

    // Synchronous-read memory stand-in.
    always @(posedge clk) mem_rdata <= memval(mem_sel, mem_addr);

    typedef struct packed {
        logic        ok;
        logic        we;
        logic [1:0]  sel;
        logic [12:0] off;
    } map_t;

    function automatic map_t map(input logic [15:0] a);
        map_t m;
        m = '0;
        if (a >= 16'h1000 && a <= 16'h17FF) begin
            m.ok = 1; m.we = 1; m.sel = 2'd0; m.off = 13'(a - 16'h1000);
        end else if (a >= 16'h1800 && a <= 16'h18FF) begin
            m.ok = 1; m.we = 0; m.sel = 2'd3; m.off = 13'(a - 16'h1800);
        end else if (a >= 16'h8000 && a <= 16'h9FFF) begin
            m.ok = 1; m.we = 1; m.sel = 2'd1; m.off = 13'(a - 16'h8000);
        end else if (a >= 16'hA000 && a <= 16'hBFFF) begin
            m.ok = 1; m.we = 1; m.sel = 2'd2; m.off = 13'(a - 16'hA000);
        end
        return m;
    endfunction

    // Reference model state
    logic        m_host, m_run, m_done, m_busy, m_err;
    logic [15:0] m_n, m_m, m_h;

    task automatic model_reset();
        m_host = 0; m_run = 0; m_done = 0; m_busy = 0; m_err = 0;
        m_n = 0; m_m = 0; m_h = 0;
    endtask

    task automatic model_write(input logic [15:0] a, input logic [31:0] d);
        map_t m;
        m = map(a);
        if (a == 16'h0004) begin
            m_done = 0;
            m_err  = 0;
            if (d[1:0] == 2'b11) m_err = 1;
            else begin
                if (d[1] && !m_run && !m_busy) m_busy = 1;
                m_host = d[0];
                m_run  = d[1];
            end
        end else if (a == 16'h0010 || a == 16'h0014 || a == 16'h0018) begin
            if (m_busy) m_err = 1;
            else if (a == 16'h0010) m_n = d[15:0];
            else if (a == 16'h0014) m_m = d[15:0];
            else m_h = d[15:0];
        end else if (m.ok && m.we) begin
            if (m_busy || m_run) m_err = 1;
        end else begin
            m_err = 1;
        end
    endtask

    task automatic model_done();
        m_done = 1; m_busy = 0; m_run = 0;
    endtask

    function automatic logic [31:0] exp_rd(input logic [15:0] a);
        map_t m;
        m = map(a);
        if (m.ok) return memval(m.sel, m.off);
        case (a)
            16'h0000: return 32'h4D4C_5001;
            16'h0004: return {30'h0, m_run, m_host};
            16'h0008: return {29'h0, m_err, m_busy, m_done};
            16'h0010: return {16'h0, m_n};
            16'h0014: return {16'h0, m_m};
            16'h0018: return {16'h0, m_h};
            default:  return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One bus cycle, entered and left at a falling edge.
    task automatic step(input logic wr, input logic [15:0] a, input logic [31:0] d,
                        input logic dn);
        map_t m;
        logic exp_we, exp_start;
        m = map(a);
        exp_we    = wr && m.ok && m.we && !m_busy && !m_run;
        exp_start = wr && a == 16'h0004 && d[1:0] == 2'b10 && !m_run && !m_busy;
        address = a; din = d; write = wr; core_done = dn;
        #1;
        chk("mem_we", mem_we, exp_we);
        if (wr && m.ok) begin
            chk("mem_sel", mem_sel, m.sel);
            chk("mem_addr", mem_addr, m.off);
        end
        if (exp_we) chk("mem_wdata", mem_wdata, d);
        @(posedge clk);
        if (wr) model_write(a, d);
        if (dn) model_done();
        @(negedge clk);
        write = 0; core_done = 0;
        chk("core_start", core_start, exp_start);
    endtask

    task automatic rd(input string tag, input logic [15:0] a);
        logic [31:0] e;
        step(0, a, 0, 0);
        e = exp_rd(a);
        @(posedge clk);
        @(negedge clk);
        chk(tag, dout, e);
    endtask

    function automatic logic [15:0] rnd_addr();
        logic [15:0] regs [8];
        regs = '{16'h0000, 16'h0004, 16'h0008, 16'h0010, 16'h0014, 16'h0018,
                 16'h000C, 16'h0FFF};
        case ($urandom_range(0, 6))
            0:       return regs[$urandom_range(0, 7)];
            1:       return 16'(16'h1000 + $urandom_range(0, 16'h07FF));
            2:       return 16'(16'h1800 + $urandom_range(0, 16'h00FF));
            3:       return 16'(16'h8000 + $urandom_range(0, 16'h1FFF));
            4:       return 16'(16'hA000 + $urandom_range(0, 16'h1FFF));
            5:       return 16'(16'h1900 + $urandom_range(0, 16'h66FF));
            default: return 16'(16'hC000 + $urandom_range(0, 16'h3FFF));
        endcase
    endfunction

    initial begin
        reset = 0; address = 0; din = 0; write = 0; core_done = 0; rd_en = 1;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_dout", dout, 0);
        chk("rst_start", core_start, 0);
        chk("rst_n", n_reg, 0);
        chk("rst_m", m_reg, 0);
        chk("rst_h", h_reg, 0);
        chk("rst_we", mem_we, 0);
        reset = 1;
        @(negedge clk);

        rd("id", 16'h0000);
        rd("status0", 16'h0008);
        rd("unmapped", 16'h4000);

        step(1, 16'h0004, 32'h1, 0);
        step(1, 16'h0010, 32'hABCD_0024, 0);
        step(1, 16'h0014, 32'd11, 0);
        step(1, 16'h0018, 32'd26, 0);
        chk("n_reg", n_reg, 36);
        chk("m_reg", m_reg, 11);
        chk("h_reg", h_reg, 26);
        for (int i = 0; i < 256; i++) step(1, 16'(16'h1000 + i), $urandom, 0);
        rd("ctrl", 16'h0004);

        step(1, 16'h0004, 32'h2, 0);
        step(0, 16'h0008, 0, 0);
        rd("status_busy", 16'h0008);
        step(1, 16'h8000, $urandom, 0);
        step(1, 16'h0010, 32'd99, 0);
        chk("n_locked", n_reg, 36);
        rd("status_err", 16'h0008);
        step(0, 16'h0008, 0, 1);
        rd("status_done", 16'h0008);
        step(1, 16'h0004, 32'h1, 0);
        rd("status_clr", 16'h0008);

        // Back-to-back result reads at one per cycle.
        for (int i = 0; i < 28; i++) begin
            if (i > 0) @(negedge clk);
            if (i >= 2) chk("res_rd", dout, memval(2'd3, 13'(i - 2)));
            if (i < 26) begin
                address = 16'(16'h1800 + i); write = 0;
                #1 chk("res_sel", mem_sel, 2'd3);
            end
        end
        @(negedge clk);

        step(1, 16'h0004, 32'h2, 0);
        step(1, 16'h0004, 32'h1, 1);
        rd("done_wins", 16'h0008);
        step(1, 16'h0004, 32'h3, 0);
        rd("ctrl_keep", 16'h0004);
        rd("ctrl_err", 16'h0008);

        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: step(1, rnd_addr(), $urandom, 0);
                4:       step(1, 16'h0004, $urandom, 0);
                5:       step(1, 16'(16'h0010 + 4 * $urandom_range(0, 2)), $urandom, 0);
                6, 7:    rd("rnd_rd", rnd_addr());
                8:       if (m_busy) step(0, 16'h0008, 0, 1);
                         else rd("rnd_status", 16'h0008);
                default: rd("rnd_status", 16'h0008);
            endcase
        end

        // Reset in the middle of a run, while the start pulse is high.
        if (m_busy) step(0, 16'h0008, 0, 1);
        step(1, 16'h0004, 32'h1, 0);
        step(1, 16'h0004, 32'h2, 0);
        #2 reset = 0;
        #1;
        chk("rst_mid_start", core_start, 0);
        chk("rst_mid_we", mem_we, 0);
        model_reset();
        @(negedge clk);
        reset = 1;
        for (int i = 0; i < 4; i++) step(0, 16'h0004, 0, 0);
        rd("rst_mid_status", 16'h0008);
        rd("rst_mid_ctrl", 16'h0004);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mlp_bus_responder.md
# mlp_bus_responder

Memory-mapped bus responder in front of the Multilayer_Perceptron core. It decodes host `address`/`write` cycles into the configuration registers (control, status, N/M/H) and into write strobes for the input, hidden-weight and output-weight memories. It returns registered read data for registers, memories and the result region. It also sequences core start/done handshakes and lock-out of host memory writes while the core runs.

## Interface
Parameters:
- ADDR_W, 16, host address width
- DATA_W, 32, host data width
- MEM_AW, 13, memory-side word address width
- ID_VALUE, 32'h4D4C_5001, read-only ID register contents

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- address  in  ADDR_W  host word address
- din  in  DATA_W  host write data
- write  in  1  host write strobe, sampled each rising edge
- read  in  1  host read qualifier; reserved, functionally ignored (a read occurs every cycle write=0)
- dout  out  DATA_W  read data, registered
- core_start  out  1  one-cycle start pulse to core
- core_done  in  1  one-cycle completion pulse from core
- n_reg, m_reg, h_reg  out  16 each  layer sizes to core
- mem_we  out  1  memory write strobe
- mem_sel  out  2  0 input, 1 hidden weights, 2 output weights, 3 result
- mem_addr  out  MEM_AW  memory word address (combinational from address)
- mem_wdata  out  DATA_W  = din
- mem_rdata  in  DATA_W  synchronous-read memory data, valid one cycle after mem_addr/mem_sel

## Operation
- Map: 0x0000 ID (RO); 0x0004 CTRL; 0x0008 STATUS (RO); 0x0010 N; 0x0014 M; 0x0018 H; 0x1000–0x17FF input mem; 0x1800–0x18FF result (RO); 0x8000–0x9FFF hidden; 0xA000–0xBFFF output weights. Other addresses: read 32'hFFFF_FFFF.
- CTRL bit0 HOST (host owns memories), bit1 RUN. Write with both bits set: CTRL unchanged, STATUS.ERR set.
- Start: CTRL write setting RUN when RUN was 0 and BUSY=0 → core_start high the next cycle for exactly one cycle, BUSY set. RUN written while BUSY: no pulse.
- STATUS bit0 DONE (sticky), bit1 BUSY, bit2 ERR (sticky); upper bits 0. core_done → DONE=1, BUSY=0, RUN cleared. Any CTRL write clears DONE and ERR; simultaneous core_done sets DONE (set wins).
- Host memory write: mem_we=write when address in a writable memory region and BUSY=0 and RUN=0. Otherwise mem_we=0; writes to result region, ID, STATUS, unmapped, or memories while locked set ERR.
- N/M/H writes take din[15:0]; ignored and ERR set while BUSY.

## Timing
- Reset values: dout 0, core_start 0, n/m/h 0, CTRL 0, STATUS 0, mem_we 0.
- Write: effective at the rising edge where write=1; mem_we combinational in that cycle.
- Read latency 1 cycle uniformly: address held at edge k → dout valid after edge k+1 (registers via registered mux; memories via sync read + registered region select). Back-to-back reads at one per cycle.
- STATUS reflects events from edge k on read issued at edge k.
- Reset asserted mid-run: core_start drops immediately, BUSY/DONE cleared; no pulse on release.

## Structure
- Package mlp_bus_pkg: region base/limit constants, CTRL/STATUS bit indices, region enum matching mem_sel encoding, ID/default-read constants.
- Sub-module mlp_addr_decode: combinational address → {region, mem_addr, writable, valid}.

## Test plan
- Reset then read 0x0000 and 0x0008 → 0x4D4C5001, 0x00000000; read 0x4000 → 0xFFFFFFFF.
- Write CTRL=001, N=36, M=11, H=26, write 0x1000..0x10FF → mem_we each cycle, mem_sel=0, mem_addr 0..255; n/m/h_reg = 36/11/26.
- Write CTRL=010 → exactly one core_start pulse next cycle, STATUS=0x2; write to 0x8000 while busy → mem_we=0, STATUS.ERR=1.
- Pulse core_done → STATUS=0x1 (plus ERR if set); write CTRL=001 → STATUS=0; reads 0x1800..0x1819 return mem_rdata with mem_sel=3, one-cycle latency, 26 consecutive words.
- core_done same cycle as CTRL write → DONE=1 afterwards; CTRL=011 → CTRL unchanged, ERR=1.
- Assert reset mid-run → core_start 0, STATUS 0 immediately; no start pulse after release.
